// File: rtl/fir_fifo_param.sv
// fir_fifo_param: time-multiplexed FIR filter (one MAC per clock, TAPS clocks per
// sample) with serial coefficient loading and a first-word-fall-through output FIFO.
// Optional feature: define FIR_SATURATE_EN to clamp results to the OUT_W signed
// range; otherwise the low OUT_W bits of the scaled accumulator are kept.
// FIFO_DEPTH must be a power of two and at least 2; TAPS must be at least 2.
module fir_fifo_param #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned COEF_W     = 12,
    parameter int unsigned TAPS       = 16,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              send_i,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              pulsador_carga_coef_i,
    input  logic              cambio_coef_i,
    input  logic              rd_en_i,
    output logic [OUT_W-1:0]  dato_out,
    output logic              dato_valid_o,
    output logic              led_full,
    output logic              overflow_o,
    output logic              coef_ready_o,
    output logic              busy_o
);

    localparam int unsigned K_W    = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    // Working width for scaling: wide enough to hold the accumulator and the output range
    localparam int unsigned EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StMac, StPush} state_e;

    state_e                   state_q;
    logic                     send_q;
    logic                     cambio_q;
    logic                     send_edge;
    logic                     cambio_edge;
    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    // Shared index: coefficient write slot in LOAD, current tap in MAC
    logic [K_W-1:0]           idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  acc_ext;
    logic signed [EXT_W-1:0]  scaled;
    logic [OUT_W-1:0]         y;
    logic                     coef_ready_q;
    logic                     busy_q;

    logic [OUT_W-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     overflow_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push_req;
    logic                     push;
    logic                     pop;

    assign send_edge   = send_i & ~send_q;
    assign cambio_edge = cambio_coef_i & ~cambio_q;

    // Edge-detector history; in reset this preloads the current level so a held input is no edge
    always_ff @(posedge clk) begin
        send_q   <= send_i;
        cambio_q <= cambio_coef_i;
    end

    // Control FSM: coefficient loading, delay-line shift, MAC sequencing, registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            acc_q        <= '0;
            coef_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pulsador_carga_coef_i) begin
                        // Button press already presents coefficient 0
                        state_q      <= StLoad;
                        busy_q       <= 1'b1;
                        coef_ready_q <= 1'b0;
                        idx_q        <= '0;
                        coef_q[0]    <= coef_in;
                    end else if (send_edge && coef_ready_q) begin
                        state_q <= StMac;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        x_q[0]  <= data_in;
                        for (int i = 1; i < TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                    end
                end
                StLoad: begin
                    if (pulsador_carga_coef_i) begin
                        idx_q     <= '0;
                        coef_q[0] <= coef_in;
                    end else if (cambio_edge) begin
                        coef_q[idx_q] <= coef_in;
                        if (idx_q == K_W'(TAPS - 1)) begin
                            state_q      <= StIdle;
                            busy_q       <= 1'b0;
                            coef_ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + K_W'(1);
                        end
                    end
                end
                StMac: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    if (idx_q == K_W'(TAPS - 1)) begin
                        state_q <= StPush;
                    end else begin
                        idx_q <= idx_q + K_W'(1);
                    end
                end
                StPush: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single shared multiplier, full-precision product for the current tap
    always_comb begin
        prod = PROD_W'(x_q[idx_q]) * PROD_W'(coef_q[idx_q]);
    end

    // Output scaling and reduction to OUT_W
`ifdef FIR_SATURATE_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        acc_ext = EXT_W'(acc_q);
        scaled  = acc_ext >>> SHIFT;
        if (scaled > SAT_MAX) begin
            y = OUT_W'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            y = OUT_W'(SAT_MIN);
        end else begin
            y = OUT_W'(scaled);
        end
    end
`else
    always_comb begin
        acc_ext = EXT_W'(acc_q);
        scaled  = acc_ext >>> SHIFT;
        y       = OUT_W'(scaled);
    end
`endif

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = (state_q == StPush);
    assign pop        = rd_en_i & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push       = push_req & (~fifo_full | pop);

    // FIFO storage has no reset; the head is masked to 0 while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= y;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign dato_out     = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign dato_valid_o = ~fifo_empty;
    assign led_full     = fifo_full;
    assign overflow_o   = overflow_q;
    assign coef_ready_o = coef_ready_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fir_fifo_param.sv
// Self-checking bench for fir_fifo_param: vector tables for impulse and step
// responses, hand sequences for load/send interlock, FIFO full and reset mid-MAC,
// and a random phase checked against a queue-based behavioural model.
module tb_fir_fifo_param;

    localparam int DATA_W     = 12;
    localparam int COEF_W     = 12;
    localparam int TAPS       = 16;
    localparam int OUT_W      = 16;
    localparam int SHIFT      = 0;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              send_i;
    logic [COEF_W-1:0] coef_in;
    logic              pulsador_carga_coef_i;
    logic              cambio_coef_i;
    logic              rd_en_i;
    logic [OUT_W-1:0]  dato_out;
    logic              dato_valid_o;
    logic              led_full;
    logic              overflow_o;
    logic              coef_ready_o;
    logic              busy_o;

    fir_fifo_param #(
        .DATA_W     (DATA_W),
        .COEF_W     (COEF_W),
        .TAPS       (TAPS),
        .OUT_W      (OUT_W),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (data_in),
        .send_i                (send_i),
        .coef_in               (coef_in),
        .pulsador_carga_coef_i (pulsador_carga_coef_i),
        .cambio_coef_i         (cambio_coef_i),
        .rd_en_i               (rd_en_i),
        .dato_out              (dato_out),
        .dato_valid_o          (dato_valid_o),
        .led_full              (led_full),
        .overflow_o            (overflow_o),
        .coef_ready_o          (coef_ready_o),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int din;
        int dexp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   spec_c [TAPS] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                            854, 376, -86, -156, 33, 136, 65, -99};
    int   cset   [TAPS];
    vec_t tbl    [32];

    // Behavioural model: coefficient set, sample history (newest first), FIFO contents
    int   mc     [TAPS];
    int   mhist  [$];
    int   mq     [$];
    bit   m_ready;
    bit   m_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int reduce(input longint acc);
        longint s;
        longint w;
        s = acc >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (s > (longint'(1) <<< (OUT_W - 1)) - 1) w = (longint'(1) <<< (OUT_W - 1)) - 1;
        else if (s < -(longint'(1) <<< (OUT_W - 1))) w = -(longint'(1) <<< (OUT_W - 1));
        else w = s;
`else
        w = s & ((longint'(1) << OUT_W) - 1);
        if (w >= (longint'(1) << (OUT_W - 1))) w = w - (longint'(1) << OUT_W);
`endif
        return int'(w);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) mc[i] = 0;
        mhist.delete();
        mq.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    // Accepted sample: y = sum of history[k] * coef[k], then into the FIFO if room
    function automatic void model_send(input int sample);
        longint acc;
        if (!m_ready) return;
        mhist.push_front(sample);
        if (mhist.size() > TAPS) void'(mhist.pop_back());
        acc = 0;
        for (int i = 0; i < mhist.size(); i++) acc += longint'(mhist[i]) * longint'(mc[i]);
        if (mq.size() < FIFO_DEPTH) mq.push_back(reduce(acc));
        else m_ovf = 1'b1;
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, "_valid"}, int'(dato_valid_o), int'(mq.size() > 0));
        chk({tag, "_full"}, int'(led_full), int'(mq.size() == FIFO_DEPTH));
        chk({tag, "_overflow"}, int'(overflow_o), int'(m_ovf));
    endtask

    // One send_i pulse and the full MAC/PUSH window; optional pop on the PUSH edge
    task automatic send(input int sample, input bit pop_at_push);
        bit acc_ok;
        bit was_empty;
        acc_ok    = m_ready;
        was_empty = (mq.size() == 0);
        data_in   = sample[DATA_W-1:0];
        send_i    = 1'b1;
        tick();
        send_i = 1'b0;
        chk("busy_after_send", int'(busy_o), int'(acc_ok));
        repeat (TAPS) tick();
        if (acc_ok && was_empty) chk("latency_early", int'(dato_valid_o), 0);
        if (pop_at_push) begin
            chk("push_pop_head", int'($signed(dato_out)), mq[0]);
            rd_en_i = 1'b1;
        end
        tick();
        rd_en_i = 1'b0;
        if (pop_at_push) void'(mq.pop_front());
        model_send(sample);
        chk("busy_done", int'(busy_o), 0);
        if (acc_ok && was_empty) chk("latency_visible", int'(dato_valid_o), 1);
        check_flags("send");
    endtask

    task automatic pop_exp(input string name, input int exp);
        chk({name, "_valid"}, int'(dato_valid_o), 1);
        chk(name, int'($signed(dato_out)), exp);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    // Button press, then TAPS cambio_coef_i edges carrying cset[0..TAPS-1]
    task automatic load_coefs(input bit with_send);
        pulsador_carga_coef_i = 1'b1;
        coef_in               = cset[0][COEF_W-1:0];
        if (with_send) begin
            data_in = 12'd9;
            send_i  = 1'b1;
        end
        tick();
        pulsador_carga_coef_i = 1'b0;
        send_i                = 1'b0;
        chk("load_busy", int'(busy_o), 1);
        chk("load_ready_low", int'(coef_ready_o), 0);
        for (int i = 0; i < TAPS; i++) begin
            coef_in       = cset[i][COEF_W-1:0];
            cambio_coef_i = 1'b1;
            tick();
            cambio_coef_i = 1'b0;
            tick();
        end
        for (int i = 0; i < TAPS; i++) mc[i] = cset[i];
        m_ready = 1'b1;
        chk("load_ready", int'(coef_ready_o), 1);
        chk("load_idle", int'(busy_o), 0);
        check_flags("load");
    endtask

    initial begin
        int run;
        int sat_exp;
        rst                   = 1'b1;
        data_in               = '0;
        send_i                = 1'b0;
        coef_in               = '0;
        pulsador_carga_coef_i = 1'b0;
        cambio_coef_i         = 1'b0;
        rd_en_i               = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_dato_out", int'(dato_out), 0);
        chk("rst_valid", int'(dato_valid_o), 0);
        chk("rst_full", int'(led_full), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        chk("rst_coef_ready", int'(coef_ready_o), 0);
        chk("rst_busy", int'(busy_o), 0);

        // Send before any coefficient load is ignored
        send(7, 1'b0);

        // Send edge mid-LOAD (idx=7) is dropped and must not shift the delay line
        for (int i = 0; i < TAPS; i++) cset[i] = spec_c[i];
        pulsador_carga_coef_i = 1'b1;
        coef_in               = cset[0][COEF_W-1:0];
        tick();
        pulsador_carga_coef_i = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (i == 7) begin
                data_in = 12'd5;
                send_i  = 1'b1;
                tick();
                send_i = 1'b0;
                tick();
                chk("midload_busy", int'(busy_o), 1);
                chk("midload_ready", int'(coef_ready_o), 0);
            end
            coef_in       = cset[i][COEF_W-1:0];
            cambio_coef_i = 1'b1;
            tick();
            cambio_coef_i = 1'b0;
            tick();
            if (i == TAPS - 2) chk("ready_before_last", int'(coef_ready_o), 0);
        end
        chk("ready_after_last", int'(coef_ready_o), 1);
        chk("midload_no_output", int'(dato_valid_o), 0);
        for (int i = 0; i < TAPS; i++) mc[i] = cset[i];
        m_ready = 1'b1;

        // Vector table: impulse response, then DC step partial sums
        run = 0;
        for (int i = 0; i < TAPS; i++) begin
            tbl[i] = '{din: int'(i == 0), dexp: spec_c[i]};
            run += spec_c[i];
            tbl[TAPS + i] = '{din: 1, dexp: run};
        end
        for (int i = 0; i < 2 * TAPS; i++) begin
            send(tbl[i].din, 1'b0);
            pop_exp($sformatf("vec%0d", i), tbl[i].dexp);
        end
        chk("step_final_entry", tbl[2 * TAPS - 1].dexp, 2246);

        // Saturation / wrap: 16 * 2047 * 2047 = 67043344 = 0x3FF0010
        for (int i = 0; i < TAPS; i++) cset[i] = 2047;
        load_coefs(1'b0);
`ifdef FIR_SATURATE_EN
        sat_exp = 32767;
`else
        sat_exp = 16;
`endif
        for (int i = 0; i < TAPS; i++) begin
            send(2047, 1'b0);
            if (i == TAPS - 1) chk("sat_16th", int'($signed(dato_out)), sat_exp);
            pop_exp("sat", mq[0]);
        end

        // Random coefficients and samples against the model
        for (int i = 0; i < TAPS; i++) cset[i] = int'($urandom_range(0, 4095)) - 2048;
        load_coefs(1'b0);
        for (int n = 0; n < 24; n++) begin
            send(int'($urandom_range(0, 4095)) - 2048, 1'b0);
            if (mq.size() > 0 && (mq.size() >= 6 || $urandom_range(0, 1) == 1)) begin
                pop_exp("rand", mq[0]);
            end
        end
        while (mq.size() > 0) pop_exp("rand_drain", mq[0]);

        // FIFO full; load press with simultaneous send edge must not start a MAC
        for (int i = 0; i < TAPS; i++) cset[i] = (i == 0) ? 1 : 0;
        load_coefs(1'b1);
        for (int v = 1; v <= FIFO_DEPTH; v++) send(v, 1'b0);
        chk("full_at_16", int'(led_full), 1);
        chk("no_overflow_at_16", int'(overflow_o), 0);
        send(17, 1'b1);
        chk("full_push_pop_full", int'(led_full), 1);
        chk("full_push_pop_no_drop", int'(overflow_o), 0);
        send(18, 1'b0);
        chk("overflow_set", int'(overflow_o), 1);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_exp($sformatf("drain%0d", i), i + 2);
        chk("drained_valid", int'(dato_valid_o), 0);
        chk("drained_full", int'(led_full), 0);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        chk("empty_pop_ignored", int'(dato_valid_o), 0);
        send(21, 1'b0);
        chk("after_empty_pop_head", int'($signed(dato_out)), 21);

        // Reset during MAC: FIFO entry, coefficients, delay line and flags all cleared
        data_in = 12'd4;
        send_i  = 1'b1;
        tick();
        send_i = 1'b0;
        repeat (5) tick();
        rst    = 1'b1;
        send_i = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("mid_rst_dato_out", int'(dato_out), 0);
        chk("mid_rst_valid", int'(dato_valid_o), 0);
        chk("mid_rst_full", int'(led_full), 0);
        chk("mid_rst_overflow", int'(overflow_o), 0);
        chk("mid_rst_coef_ready", int'(coef_ready_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        tick();
        send_i = 1'b0;
        tick();
        send(3, 1'b0);
        chk("post_rst_no_output", int'(dato_valid_o), 0);
        for (int i = 0; i < TAPS; i++) cset[i] = 1;
        load_coefs(1'b0);
        send(3, 1'b0);
        pop_exp("post_rst_cleared_line", 3);
        check_flags("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
